// File: rtl/gpio_bank_pkg.sv
// Shared constants for the GPIO bank: register address map.
package gpio_bank_pkg;

    localparam int unsigned ADDR_W = 3;

    typedef enum logic [ADDR_W-1:0] {
        ADDR_OUT         = 3'd0,
        ADDR_OE          = 3'd1,
        ADDR_IN          = 3'd2,
        ADDR_IRQ_EN_RISE = 3'd3,
        ADDR_IRQ_EN_FALL = 3'd4,
        ADDR_IRQ_STATUS  = 3'd5,
        ADDR_DEBOUNCE    = 3'd6,
        ADDR_OUT_TOGGLE  = 3'd7
    } reg_addr_e;

endpackage

// File: rtl/gpio_debounce.sv
// One pin: input synchroniser, debounce counter, stable value and edge pulses.
module gpio_debounce #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEBOUNCE_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pad_i,
    input  logic [DEBOUNCE_W-1:0] thresh_i,
    output logic                  stable_o,
    output logic                  rise_o,
    output logic                  fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_val;
    logic [DEBOUNCE_W-1:0]  cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   rise_q, fall_q;

    assign sync_val = sync_q[SYNC_STAGES-1];

    // Metastability chain, shifts toward the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
        end
    end

    // Counter runs while the synchronised value disagrees; it clears at the
    // threshold, so it can never wrap.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync_val != stable_q) begin
            if (cnt_q >= thresh_i) begin
                stable_d = sync_val;
            end else begin
                cnt_d = cnt_q + DEBOUNCE_W'(1);
            end
        end
    end

    // Debounce state and registered edge pulses, aligned with the new stable value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= stable_d & ~stable_q;
            fall_q   <= ~stable_d & stable_q;
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;

endmodule

// File: rtl/gpio_bank.sv
// Register-programmable GPIO bank: direction/output registers, debounced
// inputs, edge interrupts with W1C status and a single aggregated irq.
module gpio_bank
    import gpio_bank_pkg::*;
#(
    parameter int unsigned NUM_IOS     = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEBOUNCE_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  reg_addr,
    input  logic               reg_wr,
    input  logic               reg_rd,
    input  logic [NUM_IOS-1:0] reg_wdata,
    output logic [NUM_IOS-1:0] reg_rdata,
    input  logic [NUM_IOS-1:0] pad_in,
    output logic [NUM_IOS-1:0] pad_out,
    output logic [NUM_IOS-1:0] pad_oe,
    output logic               irq
);

    logic [NUM_IOS-1:0]    out_q, out_d;
    logic [NUM_IOS-1:0]    oe_q, oe_d;
    logic [NUM_IOS-1:0]    en_rise_q, en_rise_d;
    logic [NUM_IOS-1:0]    en_fall_q, en_fall_d;
    logic [NUM_IOS-1:0]    status_q, status_d;
    logic [DEBOUNCE_W-1:0] deb_q, deb_d;
    logic [NUM_IOS-1:0]    rdata_q, rdata_d;
    logic [NUM_IOS-1:0]    w1c;
    logic [NUM_IOS-1:0]    in_stable, rise, fall;

    // Per-pin input conditioning.
    for (genvar g = 0; g < NUM_IOS; g++) begin : g_pin
        gpio_debounce #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE_W  (DEBOUNCE_W)
        ) u_debounce (
            .clk      (clk),
            .rst_n    (rst_n),
            .pad_i    (pad_in[g]),
            .thresh_i (deb_q),
            .stable_o (in_stable[g]),
            .rise_o   (rise[g]),
            .fall_o   (fall[g])
        );
    end

    // Register writes; status set events take priority over W1C clears.
    always_comb begin
        out_d     = out_q;
        oe_d      = oe_q;
        en_rise_d = en_rise_q;
        en_fall_d = en_fall_q;
        deb_d     = deb_q;
        w1c       = '0;
        if (reg_wr) begin
            case (reg_addr)
                ADDR_OUT:         out_d     = reg_wdata;
                ADDR_OE:          oe_d      = reg_wdata;
                ADDR_IRQ_EN_RISE: en_rise_d = reg_wdata;
                ADDR_IRQ_EN_FALL: en_fall_d = reg_wdata;
                ADDR_IRQ_STATUS:  w1c       = reg_wdata;
                ADDR_DEBOUNCE:    deb_d     = DEBOUNCE_W'(reg_wdata);
                ADDR_OUT_TOGGLE:  out_d     = out_q ^ reg_wdata;
                default:          ;
            endcase
        end
        status_d = (status_q & ~w1c) | (rise & en_rise_q) | (fall & en_fall_q);
    end

    // Read mux samples pre-write register values; data holds between reads.
    always_comb begin
        rdata_d = rdata_q;
        if (reg_rd) begin
            case (reg_addr)
                ADDR_OUT:         rdata_d = out_q;
                ADDR_OE:          rdata_d = oe_q;
                ADDR_IN:          rdata_d = in_stable;
                ADDR_IRQ_EN_RISE: rdata_d = en_rise_q;
                ADDR_IRQ_EN_FALL: rdata_d = en_fall_q;
                ADDR_IRQ_STATUS:  rdata_d = status_q;
                ADDR_DEBOUNCE:    rdata_d = NUM_IOS'(deb_q);
                default:          rdata_d = '0;
            endcase
        end
    end

    // Register file state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= '0;
            oe_q      <= '0;
            en_rise_q <= '0;
            en_fall_q <= '0;
            status_q  <= '0;
            deb_q     <= '0;
            rdata_q   <= '0;
        end else begin
            out_q     <= out_d;
            oe_q      <= oe_d;
            en_rise_q <= en_rise_d;
            en_fall_q <= en_fall_d;
            status_q  <= status_d;
            deb_q     <= deb_d;
            rdata_q   <= rdata_d;
        end
    end

    assign reg_rdata = rdata_q;
    assign pad_out   = out_q;
    assign pad_oe    = oe_q;
    assign irq       = |status_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Directed and randomised checks of gpio_bank against a behavioural model.
module tb_gpio_bank;
    import gpio_bank_pkg::*;

    localparam int unsigned N  = 32;
    localparam int unsigned S  = 2;
    localparam int unsigned DW = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   reg_addr;
    logic         reg_wr, reg_rd;
    logic [N-1:0] reg_wdata, reg_rdata;
    logic [N-1:0] pad_in, pad_out, pad_oe;
    logic         irq;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    logic [31:0] m_out, m_oe, m_enr, m_enf, m_status, m_rdata, m_stable;
    logic [31:0] m_pend_r, m_pend_f;
    int unsigned m_deb;
    int unsigned m_cnt [N];
    logic [31:0] m_hist [$];

    gpio_bank #(.NUM_IOS(N), .SYNC_STAGES(S), .DEBOUNCE_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .reg_addr  (reg_addr),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .pad_in    (pad_in),
        .pad_out   (pad_out),
        .pad_oe    (pad_oe),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_out = '0; m_oe = '0; m_enr = '0; m_enf = '0; m_status = '0;
        m_rdata = '0; m_stable = '0; m_pend_r = '0; m_pend_f = '0; m_deb = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_hist.delete();
        for (int i = 0; i < S; i++) m_hist.push_back('0);
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        logic [31:0] sync, nst, w1c;
        sync = m_hist[0];
        nst  = m_stable;
        for (int i = 0; i < N; i++) begin
            if (sync[i] != m_stable[i]) begin
                if (m_cnt[i] >= m_deb) begin
                    nst[i]   = sync[i];
                    m_cnt[i] = 0;
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end else begin
                m_cnt[i] = 0;
            end
        end
        if (reg_rd) begin
            case (reg_addr)
                3'd0: m_rdata = m_out;
                3'd1: m_rdata = m_oe;
                3'd2: m_rdata = m_stable;
                3'd3: m_rdata = m_enr;
                3'd4: m_rdata = m_enf;
                3'd5: m_rdata = m_status;
                3'd6: m_rdata = 32'(m_deb);
                default: m_rdata = '0;
            endcase
        end
        w1c = (reg_wr && reg_addr == 3'd5) ? reg_wdata : '0;
        m_status = (m_status & ~w1c) | (m_pend_r & m_enr) | (m_pend_f & m_enf);
        if (reg_wr) begin
            case (reg_addr)
                3'd0: m_out = reg_wdata;
                3'd1: m_oe  = reg_wdata;
                3'd3: m_enr = reg_wdata;
                3'd4: m_enf = reg_wdata;
                3'd6: m_deb = reg_wdata % 256;
                3'd7: m_out = m_out ^ reg_wdata;
                default: ;
            endcase
        end
        m_pend_r = nst & ~m_stable;
        m_pend_f = ~nst & m_stable;
        m_stable = nst;
        void'(m_hist.pop_front());
        m_hist.push_back(pad_in);
    endtask

    // One clock cycle, then compare visible outputs with the model.
    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        chk("m_pad_out", pad_out, m_out);
        chk("m_pad_oe", pad_oe, m_oe);
        chk("m_irq", 32'(irq), 32'(|m_status));
        chk("m_rdata", reg_rdata, m_rdata);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
        step();
        reg_wr = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        reg_rd = 1'b1; reg_addr = a;
        step();
        reg_rd = 1'b0;
        d = reg_rdata;
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] b;
        rst_n = 1'b0; reg_addr = '0; reg_wr = 1'b0; reg_rd = 1'b0;
        reg_wdata = '0; pad_in = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), d);
            chk("reset_read", d, 32'h0);
        end
        chk("reset_pad_oe", pad_oe, 32'h0);
        chk("reset_pad_out", pad_out, 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);

        // Output and direction registers
        wr(ADDR_OE, 32'h0000_00FF);
        chk("oe_write", pad_oe, 32'h0000_00FF);
        wr(ADDR_OUT, 32'h0000_00A5);
        chk("out_write", pad_out, 32'h0000_00A5);
        wr(ADDR_OUT_TOGGLE, 32'h0000_000F);
        chk("out_toggle", pad_out, 32'h0000_00AA);
        rd(ADDR_OUT_TOGGLE, d);
        chk("toggle_reads_0", d, 32'h0);
        wr(ADDR_IN, 32'hFFFF_FFFF);
        rd(ADDR_IN, d);
        chk("in_ro", d, 32'h0);
        reg_rd = 1'b1;
        wr(ADDR_OUT, 32'h0000_1234);
        reg_rd = 1'b0;
        chk("rd_wr_prewrite", reg_rdata, 32'h0000_00AA);
        chk("rd_wr_newval", pad_out, 32'h0000_1234);

        // Minimum latency rise with irq
        wr(ADDR_IRQ_EN_RISE, 32'h8);
        pad_in[3] = 1'b1;
        reg_rd = 1'b1; reg_addr = ADDR_IN;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("in3_latency", reg_rdata, (k == 4) ? 32'h8 : 32'h0);
            chk("irq_latency", 32'(irq), (k == 4) ? 32'h1 : 32'h0);
        end
        reg_rd = 1'b0;
        rd(ADDR_IRQ_STATUS, d);
        chk("status_rise3", d, 32'h8);

        // Glitch rejection and debounced latency
        wr(ADDR_DEBOUNCE, 32'h4);
        wr(ADDR_IRQ_EN_RISE, 32'h9);
        pad_in[0] = 1'b1;
        repeat (3) step();
        pad_in[0] = 1'b0;
        repeat (10) step();
        rd(ADDR_IN, d);
        chk("short_pulse_in", d, 32'h8);
        rd(ADDR_IRQ_STATUS, d);
        chk("short_pulse_status", d, 32'h8);
        pad_in[0] = 1'b1;
        reg_rd = 1'b1; reg_addr = ADDR_IN;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k >= 7) chk("in0_deb_latency", reg_rdata, (k == 8) ? 32'h9 : 32'h8);
        end
        reg_rd = 1'b0;
        repeat (2) step();
        pad_in[0] = 1'b0;
        repeat (12) step();
        rd(ADDR_DEBOUNCE, d);
        chk("debounce_read", d, 32'h4);

        // W1C behaviour, set beats clear
        wr(ADDR_IRQ_STATUS, 32'hFFFF_FFFF);
        chk("clear_all_irq", 32'(irq), 32'h0);
        wr(ADDR_DEBOUNCE, 32'h0);
        wr(ADDR_IRQ_EN_RISE, 32'h20);
        wr(ADDR_IRQ_EN_FALL, 32'h20);
        pad_in[5] = 1'b1;
        repeat (6) step();
        wr(ADDR_IRQ_STATUS, 32'h20);
        chk("w1c_clear", 32'(irq), 32'h0);
        pad_in[5] = 1'b0;
        repeat (6) step();
        rd(ADDR_IRQ_STATUS, d);
        chk("status_fall5", d, 32'h20);
        wr(ADDR_IRQ_STATUS, 32'h20);
        chk("w1c_clear2", 32'(irq), 32'h0);
        pad_in[5] = 1'b1;
        repeat (3) step();
        wr(ADDR_IRQ_STATUS, 32'h20);
        chk("set_wins_irq", 32'(irq), 32'h1);
        rd(ADDR_IRQ_STATUS, d);
        chk("set_wins_status", d, 32'h20);
        wr(ADDR_IRQ_EN_FALL, 32'h0);
        chk("disable_keeps_status", 32'(irq), 32'h1);
        wr(ADDR_IRQ_STATUS, 32'h20);
        chk("w1c_deassert", 32'(irq), 32'h0);

        // Asynchronous reset mid-debounce with irq pending
        wr(ADDR_IRQ_EN_RISE, 32'h80);
        pad_in[7] = 1'b1;
        repeat (6) step();
        chk("irq_before_reset", 32'(irq), 32'h1);
        wr(ADDR_DEBOUNCE, 32'h4);
        pad_in[9] = 1'b1;
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_pad_oe", pad_oe, 32'h0);
        chk("rst_pad_out", pad_out, 32'h0);
        model_reset();
        #2;
        rst_n = 1'b1;
        reg_rd = 1'b1; reg_addr = ADDR_IN;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("post_reset_in", reg_rdata, (k == 4) ? 32'h0000_02A8 : 32'h0);
        end
        reg_rd = 1'b0;
        rd(ADDR_IRQ_STATUS, d);
        chk("post_reset_status", d, 32'h0);

        // Randomised traffic against the model
        for (int c = 0; c < 800; c++) begin
            reg_wr   = ($urandom_range(0, 3) == 0);
            reg_rd   = 1'($urandom_range(0, 1));
            reg_addr = 3'($urandom_range(0, 7));
            reg_wdata = (reg_addr == ADDR_DEBOUNCE) ? 32'($urandom_range(0, 5)) : $urandom;
            if ($urandom_range(0, 3) == 0) begin
                b = 32'd1 << $urandom_range(0, 31);
                pad_in = pad_in ^ b;
            end
            step();
        end
        reg_wr = 1'b0; reg_rd = 1'b0;
        repeat (20) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
